// File: rtl/reset_release_sequencer.sv
// Releases per-subsystem resets one stage at a time once the fabric reset is up,
// waiting a settle delay and a ready acknowledge between stages; flags stuck or lost acks.
module reset_release_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int DELAY_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  INTERNAL_RST,
  input  logic                  FABRIC_RESET_N,
  input  logic                  SOFT_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  ALL_READY,
  output logic                  TIMEOUT_ERR,
  output logic [2:0]            FAIL_STAGE
);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] DELAY_LAST   = 16'(DELAY_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_STAGE   = 3'(NUM_STAGES - 1);

  logic [1:0]            sync;
  logic                  rel;
  logic                  abort;
  state_t                state, state_d;
  logic [2:0]            k, k_d;
  logic [15:0]           cnt, cnt_d;
  logic [NUM_STAGES-1:0] stage_mask;
  logic                  ack_k;
  logic [2:0]            lowest_drop;
  logic [NUM_STAGES-1:0] rst_n_d;
  logic                  ready_d, err_d;
  logic [2:0]            fail_d;

  // Two-flop synchroniser for the upstream fabric reset.
  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) sync <= '0;
    else               sync <= {sync[0], FABRIC_RESET_N};
  end

  assign rel        = sync[1];
  assign abort      = !rel || SOFT_RST_REQ;
  assign stage_mask = NUM_STAGES'(1) << k;
  assign ack_k      = |(STAGE_ACK & stage_mask);

  always_comb begin
    lowest_drop = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!STAGE_ACK[i]) lowest_drop = 3'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d = state;
    k_d     = k;
    cnt_d   = cnt;
    rst_n_d = STAGE_RST_N;
    ready_d = ALL_READY;
    err_d   = TIMEOUT_ERR;
    fail_d  = FAIL_STAGE;

    if (abort) begin
      state_d = IDLE;
      k_d     = '0;
      cnt_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      fail_d  = '0;
    end else begin
      unique case (state)
        // The IDLE cycle counts as the first settle cycle of stage 0; later stages
        // spend that cycle on the ack handshake instead.
        IDLE: begin
          state_d = DELAY;
          cnt_d   = 16'd1;
        end
        DELAY: begin
          if (cnt == DELAY_LAST) begin
            rst_n_d = STAGE_RST_N | stage_mask;
            state_d = WAIT_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
        WAIT_ACK: begin
          if (ack_k) begin
            cnt_d = '0;
            if (k == LAST_STAGE) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              k_d     = k + 3'd1;
              state_d = DELAY;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state_d = ERROR;
            err_d   = 1'b1;
            fail_d  = k;
            rst_n_d = '0;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
        DONE: begin
          if (!(&STAGE_ACK)) begin
            state_d = ERROR;
            err_d   = 1'b1;
            fail_d  = lowest_drop;
            ready_d = 1'b0;
            rst_n_d = '0;
          end
        end
        ERROR: begin
          rst_n_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!INTERNAL_RST) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      STAGE_RST_N <= '0;
      ALL_READY   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      FAIL_STAGE  <= '0;
    end else begin
      state       <= state_d;
      k           <= k_d;
      cnt         <= cnt_d;
      STAGE_RST_N <= rst_n_d;
      ALL_READY   <= ready_d;
      TIMEOUT_ERR <= err_d;
      FAIL_STAGE  <= fail_d;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench: timestamp-based reference model compared every cycle,
// directed release-schedule/timeout/abort scenarios plus a randomized soak.
module tb_reset_release_sequencer;

  localparam int N = 4;
  localparam int D = 16;
  localparam int T = 1024;

  logic         CLK = 1'b0;
  logic         INTERNAL_RST;
  logic         FABRIC_RESET_N;
  logic         SOFT_RST_REQ;
  logic [N-1:0] STAGE_ACK;
  logic [N-1:0] STAGE_RST_N;
  logic         ALL_READY;
  logic         TIMEOUT_ERR;
  logic [2:0]   FAIL_STAGE;

  reset_release_sequencer #(
    .NUM_STAGES    (N),
    .DELAY_CYCLES  (D),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK           (CLK),
    .INTERNAL_RST  (INTERNAL_RST),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .SOFT_RST_REQ  (SOFT_RST_REQ),
    .STAGE_ACK     (STAGE_ACK),
    .STAGE_RST_N   (STAGE_RST_N),
    .ALL_READY     (ALL_READY),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .FAIL_STAGE    (FAIL_STAGE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks absolute edge numbers of the next release and the
  // ack deadline rather than running counters.
  logic [1:0]   m_sync;
  int           cyc;
  bit           m_active, m_wait, m_ready, m_err;
  int           m_k, m_release_at, m_deadline;
  logic [N-1:0] m_rst;
  logic [2:0]   m_fail;

  task automatic model_clear();
    m_active = 0; m_wait = 0; m_ready = 0; m_err = 0;
    m_k = 0; m_rst = '0; m_fail = '0;
  endtask

  task automatic model_step();
    cyc++;
    if (!m_sync[1] || SOFT_RST_REQ) begin
      model_clear();
    end else if (m_err) begin
      m_rst = '0;
    end else if (m_ready) begin
      if (STAGE_ACK != '1) begin
        m_err = 1; m_ready = 0; m_rst = '0;
        for (int i = N - 1; i >= 0; i--) if (!STAGE_ACK[i]) m_fail = 3'(i);
      end
    end else if (!m_active) begin
      m_active = 1; m_wait = 0; m_k = 0;
      m_release_at = cyc + D;
    end else if (!m_wait) begin
      if (cyc == m_release_at) begin
        m_rst[m_k] = 1'b1; m_wait = 1; m_deadline = cyc + T;
      end
    end else begin
      if (STAGE_ACK[m_k]) begin
        if (m_k == N - 1) begin
          m_ready = 1; m_active = 0; m_wait = 0;
        end else begin
          m_k++; m_wait = 0; m_release_at = cyc + D + 1;
        end
      end else if (cyc == m_deadline) begin
        m_err = 1; m_fail = 3'(m_k); m_rst = '0; m_active = 0;
      end
    end
    m_sync = {m_sync[0], FABRIC_RESET_N};
  endtask

  always @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      model_clear();
      m_sync = '0;
      cyc = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge CLK) begin
    check("cyc_rst_n", STAGE_RST_N, m_rst);
    check("cyc_ready", ALL_READY, m_ready);
    check("cyc_err",   TIMEOUT_ERR, m_err);
    check("cyc_fail",  FAIL_STAGE, m_fail);
  end

  int rel_e[N];
  int rdy_e;

  task automatic measure();
    for (int i = 0; i < N; i++) rel_e[i] = -1;
    rdy_e = -1;
    for (int e = 1; e <= 300 && rdy_e < 0; e++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) if (rel_e[i] < 0 && STAGE_RST_N[i]) rel_e[i] = e;
      if (ALL_READY) rdy_e = e;
    end
  endtask

  task automatic check_sched(input string tag, input int s0, input int s1,
                             input int s2, input int s3, input int r);
    check({tag, "_s0"}, rel_e[0], s0);
    check({tag, "_s1"}, rel_e[1], s1);
    check({tag, "_s2"}, rel_e[2], s2);
    check({tag, "_s3"}, rel_e[3], s3);
    check({tag, "_rdy"}, rdy_e, r);
  endtask

  task automatic wait_release(input int idx);
    for (int e = 0; e < 300; e++) begin
      @(posedge CLK); #1;
      if (STAGE_RST_N[idx]) break;
    end
    check("wait_release", STAGE_RST_N[idx], 1);
  endtask

  task automatic soft_pulse();
    @(posedge CLK); #1 SOFT_RST_REQ = 1'b1;
    @(posedge CLK); #1 SOFT_RST_REQ = 1'b0;
  endtask

  task automatic wait_ready();
    for (int e = 0; e < 300 && !ALL_READY; e++) begin
      @(posedge CLK); #1;
    end
    check("wait_ready", ALL_READY, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int te;
    INTERNAL_RST   = 1'b1;
    FABRIC_RESET_N = 1'b0;
    SOFT_RST_REQ   = 1'b0;
    STAGE_ACK      = '1;
    #1 INTERNAL_RST = 1'b0;
    @(posedge CLK); #1;
    check("reset_rst_n", STAGE_RST_N, 0);
    check("reset_ready", ALL_READY, 0);
    check("reset_err",   TIMEOUT_ERR, 0);
    check("reset_fail",  FAIL_STAGE, 0);
    @(posedge CLK); #1 INTERNAL_RST = 1'b1;
    repeat (3) @(posedge CLK);

    // Power-up schedule from an async fabric-reset rise.
    #3 FABRIC_RESET_N = 1'b1;
    measure();
    check_sched("boot", 19, 37, 55, 73, 74);

    // Ack loss in DONE on stages 1 and 3 together.
    STAGE_ACK = 4'b0101;
    @(posedge CLK); #1;
    check("loss_err",   TIMEOUT_ERR, 1);
    check("loss_fail",  FAIL_STAGE, 1);
    check("loss_ready", ALL_READY, 0);
    check("loss_rst_n", STAGE_RST_N, 0);

    // Soft request from ERROR clears the error and reruns the sequence.
    STAGE_ACK = '1;
    soft_pulse();
    check("soft_clr_err", TIMEOUT_ERR, 0);
    measure();
    check_sched("soft", 17, 35, 53, 71, 72);

    // Stage 2 never acknowledges.
    STAGE_ACK = 4'b1011;
    soft_pulse();
    wait_release(2);
    te = -1;
    for (int e = 1; e <= 1100; e++) begin
      @(posedge CLK); #1;
      if (TIMEOUT_ERR) begin te = e; break; end
    end
    check("to_edge",  te, 1024);
    check("to_fail",  FAIL_STAGE, 2);
    check("to_rst_n", STAGE_RST_N, 0);

    // Stage 2 acknowledges on the very last sampling edge: no error.
    soft_pulse();
    check("soft2_clr_err", TIMEOUT_ERR, 0);
    wait_release(2);
    repeat (1023) begin @(posedge CLK); #1; end
    check("late_err_pre", TIMEOUT_ERR, 0);
    STAGE_ACK[2] = 1'b1;
    @(posedge CLK); #1;
    check("late_err",   TIMEOUT_ERR, 0);
    check("late_rst_n", STAGE_RST_N, 4'b0111);
    wait_ready();

    // Fabric reset falls during the stage-2 settle delay.
    soft_pulse();
    wait_release(1);
    repeat (5) @(posedge CLK);
    #3 FABRIC_RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check("fab_hold", STAGE_RST_N, 4'b0011);
    @(posedge CLK); #1;
    check("fab_abort", STAGE_RST_N, 0);
    repeat (4) @(posedge CLK);
    #3 FABRIC_RESET_N = 1'b1;
    measure();
    check_sched("refab", 19, 37, 55, 73, 74);

    // INTERNAL_RST pulsed between edges while stage 0 waits for its ack.
    STAGE_ACK = 4'b1110;
    soft_pulse();
    wait_release(0);
    repeat (10) @(posedge CLK);
    #3 INTERNAL_RST = 1'b0;
    #1;
    check("arst_rst_n", STAGE_RST_N, 0);
    check("arst_ready", ALL_READY, 0);
    check("arst_err",   TIMEOUT_ERR, 0);
    check("arst_fail",  FAIL_STAGE, 0);
    @(posedge CLK); #1 INTERNAL_RST = 1'b1;
    STAGE_ACK = '1;
    measure();
    check_sched("arst", 19, 37, 55, 73, 74);

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      SOFT_RST_REQ = ($urandom_range(0, 299) == 0);
      if (FABRIC_RESET_N) begin
        if ($urandom_range(0, 399) == 0) FABRIC_RESET_N = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        FABRIC_RESET_N = 1'b1;
      end
      STAGE_ACK = ($urandom_range(0, 15) == 0) ? N'($urandom) : '1;
    end
    SOFT_RST_REQ = 1'b0;
    repeat (2) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
